ldpc_sram_arb: RTL and testbench

Two-requester arbiter and sequencer for the single-port LDPC message SRAM (depth ROW_WEIGHT*COL_NUMBER, 20-bit addresses, one access per cycle, registered 1-cycle read). Requester 0 is the check-node update unit and requester 1 is the variable-node update unit. Each cycle the block grants at most one access to the SRAM, supports locked bursts, rejects out-of-range addresses, and returns read data with a valid strobe to the issuing requester.

---
 rtl/ldpc_sram_arb_if.sv | 18 +
 rtl/ldpc_sram_arb.sv | 150 +++++++++++++++
 tb/tb_ldpc_sram_arb.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_sram_arb_if.sv
// Requester-side bus of the LDPC message SRAM arbiter.
// One instance per requester. The requester uses the master modport and the
// arbiter uses the slave modport. Address width is fixed at 20 bits.
interface ldpc_sram_arb_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             we;
    logic             lock;
    logic [19:0]      addr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ldpc_sram_arb.sv
// ldpc_sram_arb: arbiter and sequencer for the single-port LDPC message SRAM.
// Requester 0 is the check-node unit and requester 1 is the variable-node unit.
// The block grants at most one access per cycle and supports locked bursts.
// Out-of-range addresses are granted but dropped, and they set a sticky error.
// Read data returns one cycle after the grant, tagged to the issuing requester.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration in IDLE.
// When it is undefined, requester 0 has fixed priority.
module ldpc_sram_arb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    ldpc_sram_arb_if.slave    r0_if,
    ldpc_sram_arb_if.slave    r1_if,
    output logic              m_wen_o,
    output logic [19:0]       m_waddr_o,
    output logic [19:0]       m_raddr_o,
    output logic [WIDTH-1:0]  m_wdata_o,
    input  logic [WIDTH-1:0]  m_rdata_i,
    output logic              err_o,
    output logic              err_id_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    // The limit is one bit wider than the address, so DEPTH = 2**20 still compares correctly.
    localparam logic [20:0] LIMIT = 21'(DEPTH);

    state_e           state_q, state_d;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             prio;     // requester favoured when both ask in IDLE
    logic             sel;      // granted requester (valid when any_gnt)
    logic             any_gnt;
    logic             we_s;
    logic             lock_s;
    logic [19:0]      addr_s;
    logic [WIDTH-1:0] wdata_s;
    logic             legal;
    logic             issue;    // granted and in range: reaches the SRAM
    logic [19:0]      addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             rv_q;
    logic             rid_q;
    logic             err_q;
    logic             err_id_q;

    assign req = {r1_if.req, r0_if.req};

`ifdef SRAM_ARB_RR_EN
    logic ptr_q, ptr_d;

    assign prio = ptr_q;

    // Priority pointer: after a grant, it points at the other requester.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0])      ptr_d = 1'b1;
        else if (gnt[1]) ptr_d = 1'b0;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
`else
    assign prio = 1'b0;
`endif

    // Grant decision from the lock state, the requests and the priority.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
                else              gnt = req;
            end
            ST_LOCK0: gnt = {1'b0, req[0]};
            ST_LOCK1: gnt = {req[1], 1'b0};
            default:  gnt = 2'b00;
        endcase
        // Nothing is issued while reset is held.
        if (!rst_n) gnt = 2'b00;
    end

    // Select the granted command and decide the next lock state.
    always_comb begin
        sel     = gnt[1];
        any_gnt = |gnt;
        we_s    = sel ? r1_if.we    : r0_if.we;
        lock_s  = sel ? r1_if.lock  : r0_if.lock;
        addr_s  = sel ? r1_if.addr  : r0_if.addr;
        wdata_s = sel ? r1_if.wdata : r0_if.wdata;
        legal   = {1'b0, addr_s} < LIMIT;
        issue   = any_gnt && legal;
        // If there is no grant, either IDLE stays IDLE or the lock owner dropped its request.
        state_d = ST_IDLE;
        if (any_gnt && lock_s) state_d = sel ? ST_LOCK1 : ST_LOCK0;
    end

    // FSM and datapath registers.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rv_q     <= 1'b0;
            rid_q    <= 1'b0;
            err_q    <= 1'b0;
            err_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= m_waddr_o;
            wdata_q <= m_wdata_o;
            rv_q    <= issue && !we_s;
            rid_q   <= sel;
            if (any_gnt && !legal) begin
                err_q <= 1'b1;
                if (!err_q) err_id_q <= sel;
            end
        end
    end

    // SRAM command. Addresses and data hold their last value when nothing is issued.
    assign m_wen_o   = issue && we_s;
    assign m_waddr_o = issue ? addr_s : addr_q;
    assign m_raddr_o = m_waddr_o;
    assign m_wdata_o = issue ? wdata_s : wdata_q;

    assign r0_if.gnt = gnt[0];
    assign r1_if.gnt = gnt[1];

    // Read return. A reset cancels a pending strobe immediately.
    assign r0_if.rvalid = rst_n && rv_q && !rid_q;
    assign r1_if.rvalid = rst_n && rv_q &&  rid_q;
    assign r0_if.rdata  = m_rdata_i;
    assign r1_if.rdata  = m_rdata_i;

    assign err_o    = err_q;
    assign err_id_o = err_id_q;

endmodule

// File: tb/tb_ldpc_sram_arb.sv
// Testbench for ldpc_sram_arb: directed scenarios plus randomized traffic.
// A transaction-level model inside the bench predicts the outputs.
// It follows the build option SRAM_ARB_RR_EN.
module tb_ldpc_sram_arb;

    localparam int WIDTH = 8;
    localparam int DEPTH = 1024;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             m_wen;
    logic [19:0]      m_waddr, m_raddr;
    logic [WIDTH-1:0] m_wdata;
    logic [WIDTH-1:0] m_rdata = '0;
    logic             err, err_id;

    ldpc_sram_arb_if #(.WIDTH(WIDTH)) ri0 ();
    ldpc_sram_arb_if #(.WIDTH(WIDTH)) ri1 ();

    ldpc_sram_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_if     (ri0),
        .r1_if     (ri1),
        .m_wen_o   (m_wen),
        .m_waddr_o (m_waddr),
        .m_raddr_o (m_raddr),
        .m_wdata_o (m_wdata),
        .m_rdata_i (m_rdata),
        .err_o     (err),
        .err_id_o  (err_id)
    );

    always #5 clk = ~clk;

    // Environment SRAM: registered read, o_rdata held during write cycles.
    logic [WIDTH-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (m_wen) sram[int'(m_waddr)] <= m_wdata;
        else if (int'(m_raddr) < DEPTH) m_rdata <= sram[int'(m_raddr)];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [WIDTH-1:0] mem_model [DEPTH];
    int               mdl_owner;     // -1: nobody holds a lock, else the locked requester
    bit               mdl_ptr;
    bit               mdl_err;
    bit               mdl_err_id;
    int               mdl_last_addr;
    int               mdl_last_wdata;
    bit               pend_v;
    bit               pend_id;
    int               pend_data;

    bit               rq0, rq1, eg0, eg1, g, w, c_we, c_lock, c_legal, c_issue;
    int               c_addr, c_wdata, exp_addr, exp_wdata;

    // Compare process: predicts outputs for this cycle, then commits the cycle's events.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_gnt0", 32'(ri0.gnt), 0);
            check("rst_gnt1", 32'(ri1.gnt), 0);
            check("rst_rvalid0", 32'(ri0.rvalid), 0);
            check("rst_rvalid1", 32'(ri1.rvalid), 0);
            check("rst_wen", 32'(m_wen), 0);
            mdl_owner = -1; mdl_ptr = 0; mdl_err = 0; mdl_err_id = 0;
            mdl_last_addr = 0; mdl_last_wdata = 0; pend_v = 0;
        end else begin
            rq0 = ri0.req; rq1 = ri1.req;
            if (mdl_owner == 0)      begin eg0 = rq0; eg1 = 0; end
            else if (mdl_owner == 1) begin eg0 = 0; eg1 = rq1; end
            else if (rq0 && rq1) begin
`ifdef SRAM_ARB_RR_EN
                eg0 = (mdl_ptr == 0);
`else
                eg0 = 1;
`endif
                eg1 = !eg0;
            end else begin eg0 = rq0; eg1 = rq1; end
            g = eg0 || eg1;
            w = eg1;
            c_we    = w ? ri1.we   : ri0.we;
            c_lock  = w ? ri1.lock : ri0.lock;
            c_addr  = w ? int'(ri1.addr)  : int'(ri0.addr);
            c_wdata = w ? int'(ri1.wdata) : int'(ri0.wdata);
            c_legal = c_addr < DEPTH;
            c_issue = g && c_legal;
            exp_addr  = c_issue ? c_addr  : mdl_last_addr;
            exp_wdata = c_issue ? c_wdata : mdl_last_wdata;

            check("gnt0", 32'(ri0.gnt), 32'(eg0));
            check("gnt1", 32'(ri1.gnt), 32'(eg1));
            check("m_wen", 32'(m_wen), 32'(c_issue && c_we));
            check("m_waddr", 32'(m_waddr), exp_addr);
            check("m_raddr", 32'(m_raddr), exp_addr);
            check("m_wdata", 32'(m_wdata), exp_wdata);
            check("rvalid0", 32'(ri0.rvalid), 32'(pend_v && !pend_id));
            check("rvalid1", 32'(ri1.rvalid), 32'(pend_v && pend_id));
            if (pend_v) check("rdata", pend_id ? 32'(ri1.rdata) : 32'(ri0.rdata), pend_data);
            check("err", 32'(err), 32'(mdl_err));
            check("err_id", 32'(err_id), 32'(mdl_err_id));

            // Commit this cycle.
            pend_v = 0;
            if (g) begin
                mdl_owner = c_lock ? int'(w) : -1;
                mdl_ptr   = !w;
                if (c_legal) begin
                    if (c_we) mem_model[c_addr] = WIDTH'(c_wdata);
                    else begin
                        pend_v    = 1;
                        pend_id   = w;
                        pend_data = int'(mem_model[c_addr]);
                    end
                end else begin
                    if (!mdl_err) mdl_err_id = w;
                    mdl_err = 1;
                end
            end else begin
                mdl_owner = -1;
            end
            mdl_last_addr  = exp_addr;
            mdl_last_wdata = exp_wdata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int n, input bit req, input bit we, input bit lock,
                         input int addr, input int wdata);
        if (n == 0) begin
            ri0.req = req; ri0.we = we; ri0.lock = lock;
            ri0.addr = 20'(addr); ri0.wdata = WIDTH'(wdata);
        end else begin
            ri1.req = req; ri1.we = we; ri1.lock = lock;
            ri1.addr = 20'(addr); ri1.wdata = WIDTH'(wdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
    endtask

    bit exp_g0 [4];
    bit cur_req [2];
    bit got_gnt [2];

    initial begin
        rst_n = 1'b0;
        idle_all();
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]      = WIDTH'(i * 37 + 11);
            mem_model[i] = WIDTH'(i * 37 + 11);
        end
        @(negedge clk);
        check("reset_err", 32'(err), 0);
        check("reset_err_id", 32'(err_id), 0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_waddr", 32'(m_waddr), 0);
        check("reset_wdata", 32'(m_wdata), 0);

        // Contention right after reset: the pointer starts at 0.
`ifdef SRAM_ARB_RR_EN
        exp_g0 = '{1, 0, 1, 0};
`else
        exp_g0 = '{1, 1, 1, 1};
`endif
        step();
        drive(0, 1, 0, 0, 1, 0);
        drive(1, 1, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("contend_g0", 32'(ri0.gnt), 32'(exp_g0[i]));
            check("contend_g1", 32'(ri1.gnt), 32'(!exp_g0[i]));
            step();
        end
        idle_all();
        step();

        // Single write then read by r0.
        drive(0, 1, 1, 0, 5, 8'h3C);
        @(negedge clk); check("wr5_gnt", 32'(ri0.gnt), 1); check("wr5_wen", 32'(m_wen), 1);
        step();
        drive(0, 1, 0, 0, 5, 0);
        @(negedge clk); check("rd5_gnt", 32'(ri0.gnt), 1); check("rd5_wen", 32'(m_wen), 0);
        step();
        idle_all();
        @(negedge clk);
        check("rd5_rvalid", 32'(ri0.rvalid), 1);
        check("rd5_rdata", 32'(ri0.rdata), 32'h3C);
        check("rd5_r1_rvalid", 32'(ri1.rvalid), 0);
        step();

        // Read-after-write to address 7.
        drive(0, 1, 1, 0, 7, 8'hA5);
        step();
        drive(0, 1, 0, 0, 7, 0);
        step();
        idle_all();
        @(negedge clk);
        check("raw_rvalid", 32'(ri0.rvalid), 1);
        check("raw_rdata", 32'(ri0.rdata), 32'hA5);
        step();

        // Lock burst by r1 while r0 waits.
        drive(1, 1, 0, 1, 10, 0);
        @(negedge clk); check("lock_first_g1", 32'(ri1.gnt), 1);
        step();
        drive(0, 1, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 11 + i, 0);
            @(negedge clk);
            check("lock_g0", 32'(ri0.gnt), 0);
            check("lock_g1", 32'(ri1.gnt), 1);
            step();
        end
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk); check("lock_lost_g0", 32'(ri0.gnt), 0);
        step();
        @(negedge clk); check("lock_after_g0", 32'(ri0.gnt), 1);
        step();
        idle_all();
        step();

        // Out-of-range accesses.
        drive(1, 1, 1, 0, 1024, 8'h55);
        @(negedge clk); check("oor_g1", 32'(ri1.gnt), 1); check("oor_wen", 32'(m_wen), 0);
        step();
        idle_all();
        @(negedge clk); check("oor_err", 32'(err), 1); check("oor_err_id", 32'(err_id), 1);
        step();
        drive(0, 1, 0, 0, 2000, 0);
        @(negedge clk); check("oor2_g0", 32'(ri0.gnt), 1);
        step();
        idle_all();
        @(negedge clk);
        check("oor2_err_id", 32'(err_id), 1);
        check("oor2_rvalid", 32'(ri0.rvalid), 0);
        step();

        // Reset during an r0 locked burst with a read outstanding.
        drive(0, 1, 0, 1, 4, 0);
        @(negedge clk); check("rstb_g0", 32'(ri0.gnt), 1);
        step();
        rst_n = 1'b0;
        drive(0, 1, 0, 1, 5, 0);
        @(negedge clk);
        check("rstb_rvalid", 32'(ri0.rvalid), 0);
        check("rstb_g0_rst", 32'(ri0.gnt), 0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 6, 0);
        @(negedge clk);
        check("rstb_idle_g1", 32'(ri1.gnt), 1);
        check("rstb_err", 32'(err), 0);
        check("rstb_rvalid_after", 32'(ri0.rvalid), 0);
        step();
        idle_all();
        step();

        // Randomized traffic. Requests stay stable until granted.
        cur_req = '{0, 0};
        got_gnt = '{0, 0};
        for (int c = 0; c < 1500; c++) begin
            rst_n = (c == 700) ? 1'b0 : 1'b1;
            for (int n = 0; n < 2; n++) begin
                if (!cur_req[n] || got_gnt[n]) begin
                    cur_req[n] = ($urandom_range(0, 3) != 0);
                    drive(n, cur_req[n], 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 15) == 0) ? int'($urandom_range(1024, 4095))
                                                       : int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 255)));
                end
            end
            @(negedge clk);
            got_gnt[0] = ri0.gnt;
            got_gnt[1] = ri1.gnt;
            step();
        end
        rst_n = 1'b1;
        idle_all();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
